// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the host-request sequence and
// drives ps2c/ps2d open-drain through output-enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned RTS_CYCLES     = 200,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned PACKET_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err,
    output logic       rx_inhibit
);

    localparam int unsigned MaxA   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned MaxB   = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT
                                                                      : PACKET_TIMEOUT;
    localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {StIdle, StInhibit, StRts, StSend, StAck, StRelease} state_e;

    // Index 0 is ps2c, index 1 is ps2d.
    logic [1:0]       meta_q, sync_q, filt_q;
    logic [FiltW-1:0] fcnt_q [2];
    logic             c_prev_q;
    logic             fall_c;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_q;
    logic            first_q;
    logic [7:0]      data_q;
    logic            parity_q;
    logic            tmo;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            filt_q   <= 2'b11;
            c_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            meta_q   <= {ps2d_in, ps2c_in};
            sync_q   <= meta_q;
            c_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall_c = c_prev_q & ~filt_q[0];

    // The start window runs until the first device clock; after that the packet window applies.
    always_comb begin
        tmo = 1'b0;
        case (state_q)
            StSend:    tmo = !fall_c && (first_q ? (cnt_q >= CntW'(PACKET_TIMEOUT - 1))
                                                 : (cnt_q >= CntW'(START_TIMEOUT - 1)));
            StAck:     tmo = !fall_c && (cnt_q >= CntW'(PACKET_TIMEOUT - 1));
            StRelease: tmo = (filt_q != 2'b11) && (cnt_q >= CntW'(PACKET_TIMEOUT - 1));
            default:   tmo = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            first_q   <= 1'b0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ps2c_oe   <= 1'b0;
            ps2d_oe   <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_ack_ok <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            if (tmo) begin
                ps2c_oe   <= 1'b0;
                ps2d_oe   <= 1'b0;
                tx_err    <= 1'b1;
                tx_ack_ok <= 1'b0;
                tx_busy   <= 1'b0;
                state_q   <= StIdle;
            end else begin
                case (state_q)
                    StIdle: if (tx_start) begin
                        data_q    <= tx_data;
                        parity_q  <= ~^tx_data;
                        tx_ack_ok <= 1'b0;
                        tx_busy   <= 1'b1;
                        ps2c_oe   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StInhibit;
                    end
                    StInhibit: if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                        ps2d_oe <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRts;
                    end
                    StRts: if (cnt_q == CntW'(RTS_CYCLES - 1)) begin
                        ps2c_oe <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        first_q <= 1'b0;
                        state_q <= StSend;
                    end
                    StSend: if (fall_c) begin
                        first_q <= 1'b1;
                        bit_q   <= bit_q + 1'b1;
                        if (!first_q) cnt_q <= '0;
                        if (bit_q == 4'd9) begin
                            ps2d_oe <= 1'b0;
                            state_q <= StAck;
                        end else if (bit_q == 4'd8) begin
                            ps2d_oe <= ~parity_q;
                        end else begin
                            ps2d_oe <= ~data_q[bit_q[2:0]];
                        end
                    end
                    StAck: if (fall_c) begin
                        tx_ack_ok <= ~filt_q[1];
                        cnt_q     <= '0;
                        state_q   <= StRelease;
                    end
                    StRelease: if (filt_q == 2'b11) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rx_inhibit = tx_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model and a byte scoreboard.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_ack_ok, tx_err, rx_inhibit;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .RTS_CYCLES    (10),
        .FILTER_LEN    (2),
        .START_TIMEOUT (5000),
        .PACKET_TIMEOUT(5000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2c_oe   (ps2c_oe),
        .ps2d_oe   (ps2d_oe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_ack_ok (tx_ack_ok),
        .tx_err    (tx_err),
        .rx_inhibit(rx_inhibit)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device model: clocks nclk bits (40-cycle half-period), samples data mid-high, then acks.
    task automatic device_frame(input int nclk, input bit ack, input int inject_at,
                                input int glitch_at, output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", 32'(n < 2000), 32'd1);
        repeat (30) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            dev_c_low = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (i == inject_at && k == 10) begin
                    tx_start = 1'b1;
                    tx_data  = 8'h00;
                end else if (i == inject_at && k == 11) begin
                    tx_start = 1'b0;
                end
            end
            dev_c_low = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (i == glitch_at && k == 5) dev_c_low = 1'b1;
                else if (i == glitch_at && k == 6) dev_c_low = 1'b0;
                if (k == 20 && i < 10) bits[i] = ps2d_in;
            end
        end
        if (nclk >= 10) begin
            if (ack) dev_d_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (40) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (20) @(negedge clk);
            dev_d_low = 1'b0;
        end
    endtask

    task automatic check_frame(input logic [9:0] bits);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("data_byte", 32'(bits[7:0]), 32'(e));
        check("parity_bit", 32'(bits[8]), 32'(~^e));
        check("stop_bit", 32'(bits[9]), 32'd1);
    endtask

    task automatic wait_done(input int d0, input int e0, input bit exp_ack);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("err_count", 32'(err_cnt - e0), 32'd0);
        check("ack_ok", 32'(tx_ack_ok), 32'(exp_ack));
        check("busy_after", 32'(tx_busy), 32'd0);
        check("inhibit_after", 32'(rx_inhibit), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, e0, n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_c_oe", 32'(ps2c_oe), 32'd0);
        check("rst_d_oe", 32'(ps2d_oe), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_ack", 32'(tx_ack_ok), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Ack path with phase timing
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hF4);
        check("accept_busy", 32'(tx_busy), 32'd1);
        check("accept_inhibit", 32'(rx_inhibit), 32'd1);
        n = 0;
        while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'd100);
        n = 0;
        while (ps2c_oe === 1'b1 && ps2d_oe === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("rts_len", 32'(n), 32'd10);
        device_frame(10, 1'b1, -1, -1, bits);
        check_frame(bits);
        wait_done(d0, e0, 1'b1);

        // Nack path
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hFF);
        device_frame(10, 1'b0, -1, -1, bits);
        check_frame(bits);
        wait_done(d0, e0, 1'b0);

        // Busy rejection: second request during bit 3
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hF4);
        device_frame(10, 1'b1, 3, -1, bits);
        check_frame(bits);
        wait_done(d0, e0, 1'b1);
        repeat (300) @(negedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("idle_after_reject", 32'(tx_busy), 32'd0);

        // Glitch rejection on ps2c during SEND
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'h3C);
        device_frame(10, 1'b1, -1, 2, bits);
        check_frame(bits);
        wait_done(d0, e0, 1'b1);

        // Reset mid-transfer at bit 4, then a clean transfer
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hF4);
        device_frame(4, 1'b1, -1, -1, bits);
        void'(exp_q.pop_front());
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_c_oe", 32'(ps2c_oe), 32'd0);
        check("mid_rst_d_oe", 32'(ps2d_oe), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        repeat (200) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
        send_cmd(8'hA5);
        device_frame(10, 1'b1, -1, -1, bits);
        check_frame(bits);
        wait_done(d0, e0, 1'b1);

        // Start timeout: device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'h55);
        void'(exp_q.pop_front());
        n = 0;
        while (ps2c_oe === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("start_tmo_len", 32'(n), 32'd5000);
        check("tmo_c_oe", 32'(ps2c_oe), 32'd0);
        check("tmo_d_oe", 32'(ps2d_oe), 32'd0);
        check("tmo_busy", 32'(tx_busy), 32'd0);
        check("tmo_ack", 32'(tx_ack_ok), 32'd0);
        repeat (20) @(negedge clk);
        check("tmo_err_count", 32'(err_cnt - e0), 32'd1);
        check("tmo_no_done", 32'(done_cnt - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter for the mouse port.
- Sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") to the device using the PS/2 host-request protocol.
- Drives the shared ps2c/ps2d lines open-drain through output-enables; the top level builds the tristate.
- Sits beside the mouse receiver and raises `rx_inhibit` so the receiver ignores line activity during a host transmission.

Parameters:
INHIBIT_CYCLES, 12000, clock-low inhibit time in clk cycles (120 us at 100 MHz)
RTS_CYCLES, 200, clock-low + data-low overlap before releasing clock
FILTER_LEN, 8, consecutive equal samples needed to accept a new ps2c/ps2d level
START_TIMEOUT, 1500000, max cycles from clock release to first device falling edge (15 ms)
PACKET_TIMEOUT, 200000, max cycles from first falling edge to ack (2 ms)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous reset, active-low
ps2c_in  in  1  raw PS/2 clock pin level
ps2d_in  in  1  raw PS/2 data pin level
tx_data  in  8  command byte, sampled when tx_start is accepted
tx_start  in  1  request to send; accepted only in IDLE
ps2c_oe  out  1  1 = pull ps2c low; 0 = release
ps2d_oe  out  1  1 = pull ps2d low; 0 = release
tx_busy  out  1  high from acceptance until completion
tx_done  out  1  one-cycle pulse at completion (ack or nack)
tx_ack_ok  out  1  level, valid from tx_done; 1 = device acked
tx_err  out  1  one-cycle pulse on timeout (tx_done not pulsed)
rx_inhibit  out  1  equals tx_busy

Behaviour:
- Reset: one clk and reset are decided; reset is synchronous and active-low. When reset=0 at a clk edge, all outputs go to 0, the state goes to IDLE, and the counters and filters clear (filter levels to 1).
- Reset mid-operation: lines are released on that same edge. No tx_done or tx_err is produced.
- Input conditioning:
  - 2-FF synchronizer, then a glitch filter. The filtered level changes only after FILTER_LEN identical consecutive samples.
  - fall_c is a one-cycle pulse when the filtered ps2c goes 1->0.
- Acceptance: tx_start=1 in IDLE latches tx_data and parity = ~^tx_data (odd parity). tx_start outside IDLE is ignored, and tx_data changes after acceptance are ignored.
- States and transitions:
  - IDLE: oe=00. On tx_start -> INHIBIT. tx_busy=1 and ps2c_oe=1 on the next edge (latency 1 cycle).
  - INHIBIT: ps2c_oe=1, ps2d_oe=0 for INHIBIT_CYCLES cycles -> RTS.
  - RTS: ps2c_oe=1, ps2d_oe=1 for RTS_CYCLES cycles -> SEND. The start bit (0) is now on data.
  - SEND: ps2c_oe=0, ps2d_oe holds the start bit.
    - Bit counter n=0. On each fall_c, n increments and ps2d_oe is updated in the same cycle:
    - n=1..8: ps2d_oe = ~tx_data[n-1] (LSB first).
    - n=9: ps2d_oe = ~parity.
    - n=10: ps2d_oe=0 (stop bit, data released) -> ACK.
  - ACK: wait for fall_c, then sample filtered ps2d. tx_ack_ok = ~ps2d (0 = ack). -> RELEASE.
  - RELEASE: wait until filtered ps2c=1 and ps2d=1. Then one-cycle tx_done, tx_busy=0 -> IDLE.
- Timeouts: counter starts on entering SEND.
  - No fall_c within START_TIMEOUT: -> ERR.
  - After the first fall_c, the counter restarts. ACK not finished within PACKET_TIMEOUT: -> ERR.
  - The RELEASE wait is also bounded by PACKET_TIMEOUT.
- ERR: oe=00, tx_err pulses one cycle, tx_ack_ok=0, tx_busy=0 -> IDLE.
- Line timing: a data bit changes only while ps2c is low, i.e. within the cycle of fall_c. Ambiguous timing is never sampled.
- tx_ack_ok holds its value until the next acceptance, which clears it to 0.

Test Plan:
- Parameters for all tests: INHIBIT=100, RTS=10, FILTER_LEN=2, START_TIMEOUT=5000, PACKET_TIMEOUT=5000. A device model clocks at 40-cycle half-period.
- Ack path: tx_data=0xF4 with device ack.
  - ps2c_oe=1 for 100 cycles, then ps2c_oe=1 and ps2d_oe=1 for 10 cycles.
  - Device samples bits 0,0,1,0,1,1,1,1, parity=0, stop=1.
  - Device drives ack low -> tx_done pulse, tx_ack_ok=1, tx_busy=0.
- Nack path: tx_data=0xFF, device leaves data high at edge 11.
  - Parity=1 sampled.
  - tx_done pulse with tx_ack_ok=0; tx_err stays 0.
- Start timeout: device never clocks -> 5000 cycles after SEND entry, tx_err pulses, oe=00, tx_busy=0, tx_done never asserted.
- Busy rejection: second tx_start with tx_data=0x00 during bit 3 of a 0xF4 transfer -> ignored; the device still receives 0xF4 and exactly one tx_done occurs.
- Reset mid-transfer: reset=0 for 1 cycle at bit 4 -> next edge oe=00, tx_busy=0, no tx_done/tx_err; a new tx_start afterwards sends correctly.
- Glitch rejection: 1-cycle low glitch on ps2c_in during SEND (FILTER_LEN=2) -> bit counter unchanged; the byte is still received correctly.
